// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer with press/release pulses and a
// lowest-index-first queue of pending press events.
module switch_debouncer #(
  parameter  int WIDTH           = 16,
  parameter  int DEBOUNCE_CYCLES = 20,
  localparam int IDX_W           = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic             key_valid_o,
  output logic [IDX_W-1:0] key_idx_o
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] press_q;
  logic [WIDTH-1:0] release_q;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] serve;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [IDX_W-1:0] low_idx;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw_i;
      sync <= meta;
    end
  end

  // A channel toggles on the edge where its mismatch run reaches full length.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = (sync[i] != stable_q[i]) &&
                  (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  // Per-channel mismatch run-length counters.
  always_ff @(posedge clk_i) begin
    // NOTE: the counter array is reset explicitly; a count surviving reset
    // would let pre-reset bounce history complete a debounce afterwards.
    if (rst_i) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable_q[i] || toggle[i]) cnt[i] <= '0;
        else                                     cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Debounced level plus registered edge pulses aligned with the new level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      stable_q  <= stable_q ^ toggle;
      press_q   <= toggle & ~stable_q;
      release_q <= toggle & stable_q;
    end
  end

  // Lowest pending channel: one-hot serve mask and its binary index.
  always_comb begin
    serve   = pending & (~pending + 1'b1);
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IDX_W'(i);
    end
  end

  // Pending press mask; a new press wins over a same-edge serve of that bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) pending <= '0;
    else       pending <= (pending & ~serve) | press_q;
  end

  assign stable_o    = stable_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign key_valid_o = |pending;
  assign key_idx_o   = low_idx;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch
// activity, all compared every cycle against a behavioural model.
module tb_switch_debouncer;

  localparam int WIDTH = 16;
  localparam int D     = 4;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable, press, release_p;
  logic             key_valid;
  logic [IDX_W-1:0] key_idx;

  int checks   = 0;
  int failures = 0;

  // Model state: raw history, history of synchronized samples seen at edges.
  logic [WIDTH-1:0] raw_q[$];
  logic [WIDTH-1:0] sync_q[$];
  logic [WIDTH-1:0] m_stable, m_press, m_release, m_pending;

  switch_debouncer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(D)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .raw_i      (raw),
    .stable_o   (stable),
    .press_o    (press),
    .release_o  (release_p),
    .key_valid_o(key_valid),
    .key_idx_o  (key_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) if (v[i]) return i;
    return 0;
  endfunction

  // A level is accepted once the last D synchronized samples all disagree
  // with the current debounced level; the synchronized value is the raw
  // level from two edges back.
  task automatic model_edge();
    logic [WIDTH-1:0] sync_now, tog, served;
    bit all_diff;
    if (rst) begin
      raw_q.delete();
      sync_q.delete();
      m_stable  = '0;
      m_press   = '0;
      m_release = '0;
      m_pending = '0;
      return;
    end
    sync_now = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : '0;
    raw_q.push_back(raw);
    if (raw_q.size() > 2) void'(raw_q.pop_front());
    sync_q.push_back(sync_now);
    if (sync_q.size() > D) void'(sync_q.pop_front());
    tog = '0;
    if (sync_q.size() == D) begin
      for (int i = 0; i < WIDTH; i++) begin
        all_diff = 1'b1;
        foreach (sync_q[k]) if (sync_q[k][i] == m_stable[i]) all_diff = 1'b0;
        tog[i] = all_diff;
      end
    end
    served    = (m_pending != '0) ? (WIDTH'(1) << lowest(m_pending)) : '0;
    m_pending = (m_pending & ~served) | m_press;
    m_press   = tog & ~m_stable;
    m_release = tog & m_stable;
    m_stable  = m_stable ^ tog;
  endtask

  // One clock: update the model at the edge, compare every output 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("stable",    stable,    m_stable);
    check("press",     press,     m_press);
    check("release",   release_p, m_release);
    check("key_valid", key_valid, (m_pending != '0));
    check("key_idx",   key_idx,   (m_pending != '0) ? lowest(m_pending) : 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    raw = '0;
    m_stable = '0; m_press = '0; m_release = '0; m_pending = '0;

    // Reset state.
    ticks(2);
    check("rst_stable", stable, 0);
    check("rst_press",  press,  0);
    check("rst_valid",  key_valid, 0);
    rst = 1'b0;
    ticks(3);

    // Clean press on channel 3: new level after edge E+5, event one cycle later.
    raw[3] = 1'b1;
    ticks(5);
    check("clean_stable_early", stable, 16'h0000);
    tick();
    check("clean_stable", stable, 16'h0008);
    check("clean_press",  press,  16'h0008);
    tick();
    check("clean_press_gone", press, 16'h0000);
    check("clean_valid", key_valid, 1);
    check("clean_idx",   key_idx,   3);
    tick();
    check("clean_valid_done", key_valid, 0);
    raw[3] = 1'b0;
    ticks(8);

    // Bounce on channel 0: toggles every 2 cycles, never accepted.
    for (int k = 0; k < 20; k++) begin
      raw[0] = ((k / 2) % 2 == 0);
      tick();
      check("bounce_stable", stable[0], 0);
      check("bounce_press",  press[0],  0);
      check("bounce_valid",  key_valid, 0);
    end
    raw[0] = 1'b0;
    ticks(8);

    // Simultaneous press on four channels, served lowest index first.
    raw = 16'h8421;
    ticks(5);
    check("simul_press_early", press, 16'h0000);
    tick();
    check("simul_press", press, 16'h8421);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("simul_valid", key_valid, 1);
      check("simul_idx",   key_idx,   5 * k);
    end
    tick();
    check("simul_valid_done", key_valid, 0);
    raw = '0;
    ticks(8);

    // Release on channel 7: pulse after D+1 edges, no key event.
    raw[7] = 1'b1;
    ticks(8);
    raw[7] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("release_pulse", release_p, (k == 6) ? 16'h0080 : 16'h0000);
      check("release_valid", key_valid, 0);
    end

    // Reset during a count with channel 2 held high: full debounce afterwards.
    raw[2] = 1'b1;
    ticks(3);
    rst = 1'b1;
    ticks(2);
    check("midrst_stable", stable, 0);
    check("midrst_press",  press,  0);
    check("midrst_valid",  key_valid, 0);
    check("midrst_idx",    key_idx,   0);
    rst = 1'b0;
    ticks(5);
    check("midrst_press_early", press, 16'h0000);
    tick();
    check("midrst_press", press, 16'h0004);
    tick();
    check("midrst_valid_post", key_valid, 1);
    check("midrst_idx_post",   key_idx,   2);
    raw = '0;
    ticks(8);

    // Random switch activity with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(0, 7) == 0) raw[i] = ~raw[i];
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of raw switch channels (min 1, max 32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20, consecutive stable cycles needed to accept a level change (min 1).
REQ-003 SHALL have port clk_i  input  1  single clock domain; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port raw_i  input  WIDTH  raw switch levels, asynchronous to clk_i, may bounce.
REQ-006 SHALL have port stable_o  output  WIDTH  debounced level per channel.
REQ-007 SHALL have port press_o  output  WIDTH  one-cycle pulse per channel on debounced 0->1.
REQ-008 SHALL have port release_o  output  WIDTH  one-cycle pulse per channel on debounced 1->0.
REQ-009 SHALL have port key_valid_o  output  1  one-cycle pulse: one queued press event presented.
REQ-010 SHALL have port key_idx_o  output  $clog2(WIDTH) (min 1)  channel index of presented press; 0 when key_valid_o low.

Function
REQ-011 SHALL pass each raw_i bit through a two-flop synchronizer; sync value = raw_i sampled two edges earlier.
REQ-012 SHALL keep one counter per channel, width $clog2(DEBOUNCE_CYCLES)+1, cleared on any cycle sync == stable.
REQ-013 SHALL, per edge with sync != stable: if counter == DEBOUNCE_CYCLES-1, toggle stable and clear counter; else increment counter.
REQ-014 SHALL yield latency: raw_i level held constant from sampling edge E changes stable_o after edge E+DEBOUNCE_CYCLES+1.
REQ-015 SHALL reject any sync mismatch lasting fewer than DEBOUNCE_CYCLES cycles: counter clears, stable_o unchanged, no pulses.
REQ-016 SHALL assert press_o[i] (release_o[i]) from registers exactly during the first cycle stable_o[i] reads 1 (0) after a toggle; never both at once for one channel.
REQ-017 SHALL treat channels independently; simultaneous toggles on several channels each produce their own pulses in the same cycle.
REQ-018 SHALL hold a WIDTH-bit pending mask; each press_o bit ORs into pending one edge later; re-press of an already-pending channel merges (no duplicate).
REQ-019 SHALL, each cycle pending != 0, present the lowest set index: key_valid_o=1, key_idx_o=index, and clear that bit at the next edge; at most one event per cycle.
REQ-020 SHALL, on same-edge set (new press) and clear (serve) of one bit, give set priority: bit remains pending, event presented again.
REQ-021 SHALL present a lone press on key_valid_o/key_idx_o in the cycle after its press_o pulse.
REQ-022 SHALL not count release events into the pending mask.

Reset
REQ-023 SHALL, while rst_i high at an edge, clear synchronizer flops, counters, stable_o, press_o, release_o, pending, key_valid_o, key_idx_o to 0.
REQ-024 SHALL abort any in-progress debounce count on reset; no pulse generated from pre-reset history.
REQ-025 SHALL treat a switch held high through reset deassertion as a new press: full debounce, then press_o and key event.

Verification
REQ-026 SHALL cover clean press: DEBOUNCE_CYCLES=4, raw_i[3] 0->1 before edge E -> stable_o[3]=1 after edge E+5, press_o=0x0008 for one cycle, next cycle key_valid_o=1, key_idx_o=3.
REQ-027 SHALL cover bounce: raw_i[0] toggles every 2 cycles for 20 cycles, DEBOUNCE_CYCLES=4 -> stable_o, press_o, key_valid_o stay 0.
REQ-028 SHALL cover simultaneous press: raw_i 0x0000->0x8421 -> press_o=0x8421 for one cycle, then key_idx_o 0,5,10,15 on four consecutive cycles with key_valid_o high, then low.
REQ-029 SHALL cover release: channel 7 held high then dropped -> release_o=0x0080 one cycle DEBOUNCE_CYCLES+1 edges after sampling, no key event.
REQ-030 SHALL cover reset mid-operation: rst_i pulsed during count with raw_i[2]=1 held -> all outputs 0 during reset, press_o[2] after full DEBOUNCE_CYCLES+2 post-reset edges, key_idx_o=2 next cycle.
